// File: rtl/proj_slot_arbiter.sv
// proj_slot_arbiter
// Allocates on-screen projectile slots between the boss burst sequencer and
// the player fire logic. One grant per clock, round-robin between the two
// requesters, lowest free slot first. Slots are handed back via slot_release.
`timescale 1ns/1ps

module proj_slot_arbiter #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3,
  parameter int BURST_MAX = 5
) (
  input  logic                 clk_master,
  input  logic                 rst_n,
  input  logic                 boss_req,
  input  logic [2:0]           boss_count,
  input  logic                 player_req,
  input  logic [NUM_SLOTS-1:0] slot_release,
  output logic                 grant_valid,
  output logic                 grant_owner,
  output logic [SLOT_W-1:0]    grant_slot,
  output logic [2:0]           grant_idx,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] slot_owner,
  output logic                 boss_busy,
  output logic                 boss_drop,
  output logic                 player_drop,
  output logic                 boss_overrun
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic OWNER_BOSS   = 1'b0;
  localparam logic OWNER_PLAYER = 1'b1;
  localparam logic [2:0] BURST_MAX_C = 3'(BURST_MAX);
  localparam logic [NUM_SLOTS-1:0] ONE_HOT_BASE = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [2:0]            burst_rem_r;
  logic [2:0]            burst_idx_r;
  logic                  player_pend_r;
  logic                  last_grant_r;

  logic                  boss_cand_s;
  logic                  player_cand_s;
  logic                  player_wins_s;
  logic                  boss_wins_s;
  logic                  free_found_s;
  logic [SLOT_W-1:0]     free_slot_s;
  logic [NUM_SLOTS-1:0]  grant_mask_s;
  logic [NUM_SLOTS-1:0]  busy_next_s;
  logic [NUM_SLOTS-1:0]  owner_next_s;
  logic [2:0]            burst_load_s;

  // Lowest-index slot whose busy bit is clear (0 when none is free).
  function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] busy);
    logic [SLOT_W-1:0] idx;
    idx = {SLOT_W{1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx = SLOT_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Arbitration, free-slot search and next occupancy/ownership maps.
  always_comb begin
    boss_cand_s   = (state_r == ST_BURST) && (burst_rem_r != 3'd0);
    player_cand_s = player_pend_r;
    // Player wins when alone, or on a tie when the boss was granted last.
    if (player_cand_s && (!boss_cand_s || (last_grant_r == OWNER_BOSS))) begin
      player_wins_s = 1'b1;
    end else begin
      player_wins_s = 1'b0;
    end
    boss_wins_s  = boss_cand_s && !player_wins_s;
    free_found_s = ~(&slot_busy);
    free_slot_s  = lowest_free(slot_busy);
    if ((boss_wins_s || player_wins_s) && free_found_s) begin
      grant_mask_s = ONE_HOT_BASE << free_slot_s;
    end else begin
      grant_mask_s = {NUM_SLOTS{1'b0}};
    end
    // Release clears at this edge; the allocator only ever picks a slot that
    // was already free, so a grant and a release never target the same bit.
    busy_next_s = (slot_busy & ~slot_release) | grant_mask_s;
    if (player_wins_s) begin
      owner_next_s = slot_owner | grant_mask_s;
    end else begin
      owner_next_s = slot_owner & ~grant_mask_s;
    end
    if (boss_count > BURST_MAX_C) begin
      burst_load_s = BURST_MAX_C;
    end else begin
      burst_load_s = boss_count;
    end
  end

  // Burst FSM, pending-shot flag, round-robin pointer and all registered outputs.
  always_ff @(posedge clk_master or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      burst_rem_r   <= 3'd0;
      burst_idx_r   <= 3'd0;
      player_pend_r <= 1'b0;
      last_grant_r  <= OWNER_PLAYER;
      grant_valid   <= 1'b0;
      grant_owner   <= 1'b0;
      grant_slot    <= {SLOT_W{1'b0}};
      grant_idx     <= 3'd0;
      slot_busy     <= {NUM_SLOTS{1'b0}};
      slot_owner    <= {NUM_SLOTS{1'b0}};
      boss_busy     <= 1'b0;
      boss_drop     <= 1'b0;
      player_drop   <= 1'b0;
      boss_overrun  <= 1'b0;
    end else begin
      grant_valid  <= 1'b0;
      grant_owner  <= 1'b0;
      grant_slot   <= {SLOT_W{1'b0}};
      grant_idx    <= 3'd0;
      boss_drop    <= 1'b0;
      player_drop  <= 1'b0;
      boss_overrun <= 1'b0;
      slot_busy    <= busy_next_s;
      slot_owner   <= owner_next_s;

      case (state_r)
        ST_IDLE: begin
          if (boss_req && (boss_count != 3'd0)) begin
            burst_rem_r <= burst_load_s;
            burst_idx_r <= 3'd0;
            state_r     <= ST_BURST;
            boss_busy   <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
            boss_busy   <= 1'b0;
          end
        end
        ST_BURST: begin
          if (boss_req) begin
            boss_overrun <= 1'b1;
          end else begin
            boss_overrun <= 1'b0;
          end
          if (boss_wins_s) begin
            last_grant_r <= OWNER_BOSS;
            if (free_found_s) begin
              grant_valid <= 1'b1;
              grant_owner <= OWNER_BOSS;
              grant_slot  <= free_slot_s;
              grant_idx   <= burst_idx_r;
              burst_idx_r <= burst_idx_r + 3'd1;
              burst_rem_r <= burst_rem_r - 3'd1;
              if (burst_rem_r == 3'd1) begin
                state_r   <= ST_IDLE;
                boss_busy <= 1'b0;
              end else begin
                state_r   <= ST_BURST;
              end
            end else begin
              // Pool full: discard the remainder of the burst.
              boss_drop   <= 1'b1;
              burst_rem_r <= 3'd0;
              state_r     <= ST_IDLE;
              boss_busy   <= 1'b0;
            end
          end else if (burst_rem_r == 3'd0) begin
            state_r   <= ST_IDLE;
            boss_busy <= 1'b0;
          end else begin
            state_r   <= ST_BURST;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          burst_rem_r <= 3'd0;
          boss_busy   <= 1'b0;
        end
      endcase

      // A serviced shot clears the flag; a request landing that same cycle merges.
      if (player_wins_s) begin
        player_pend_r <= 1'b0;
        last_grant_r  <= OWNER_PLAYER;
        if (free_found_s) begin
          grant_valid <= 1'b1;
          grant_owner <= OWNER_PLAYER;
          grant_slot  <= free_slot_s;
          grant_idx   <= 3'd0;
        end else begin
          player_drop <= 1'b1;
        end
      end else begin
        player_pend_r <= player_pend_r | player_req;
      end
    end
  end

endmodule

// File: tb/tb_proj_slot_arbiter.sv
// Scoreboard bench for proj_slot_arbiter: directed stimulus pushes expected
// grant/drop/overrun events, a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_proj_slot_arbiter;
  localparam int NS = 8;
  localparam int SW = 3;
  localparam logic [1:0] K_GRANT = 2'd0;
  localparam logic [1:0] K_BDROP = 2'd1;
  localparam logic [1:0] K_PDROP = 2'd2;
  localparam logic [1:0] K_OVR   = 2'd3;

  logic          clk_master = 1'b0;
  logic          rst_n = 1'b0;
  logic          boss_req = 1'b0;
  logic [2:0]    boss_count = 3'd0;
  logic          player_req = 1'b0;
  logic [NS-1:0] slot_release = '0;
  logic          grant_valid;
  logic          grant_owner;
  logic [SW-1:0] grant_slot;
  logic [2:0]    grant_idx;
  logic [NS-1:0] slot_busy;
  logic [NS-1:0] slot_owner;
  logic          boss_busy;
  logic          boss_drop;
  logic          player_drop;
  logic          boss_overrun;

  proj_slot_arbiter #(.NUM_SLOTS(NS), .SLOT_W(SW), .BURST_MAX(5)) dut (
    .clk_master  (clk_master),
    .rst_n       (rst_n),
    .boss_req    (boss_req),
    .boss_count  (boss_count),
    .player_req  (player_req),
    .slot_release(slot_release),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner),
    .grant_slot  (grant_slot),
    .grant_idx   (grant_idx),
    .slot_busy   (slot_busy),
    .slot_owner  (slot_owner),
    .boss_busy   (boss_busy),
    .boss_drop   (boss_drop),
    .player_drop (player_drop),
    .boss_overrun(boss_overrun)
  );

  always #5 clk_master = ~clk_master;

  typedef struct {
    logic [1:0]    kind;
    logic          owner;
    logic [SW-1:0] slot;
    logic [2:0]    idx;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push_ev(input logic [1:0] k, input logic o, input logic [SW-1:0] s, input logic [2:0] i);
    exp_t e;
    e.kind = k; e.owner = o; e.slot = s; e.idx = i;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic see(input logic [1:0] k, input logic o, input logic [SW-1:0] s, input logic [2:0] i);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d owner=%0d slot=%0d idx=%0d, expected none at %0t", k, o, s, i, $time);
    end else begin
      e = q.pop_front();
      if ((e.kind !== k) || ((k == K_GRANT) && ((e.owner !== o) || (e.slot !== s) || (e.idx !== i)))) begin
        errors++;
        $display("FAIL event: got kind=%0d owner=%0d slot=%0d idx=%0d, expected kind=%0d owner=%0d slot=%0d idx=%0d at %0t",
                 k, o, s, i, e.kind, e.owner, e.slot, e.idx, $time);
      end
    end
  endtask

  // Monitor: every output pulse is matched against the next expected event.
  always @(negedge clk_master) begin
    if (rst_n) begin
      if (grant_valid)  see(K_GRANT, grant_owner, grant_slot, grant_idx);
      if (boss_drop)    see(K_BDROP, 1'b0, '0, 3'd0);
      if (player_drop)  see(K_PDROP, 1'b0, '0, 3'd0);
      if (boss_overrun) see(K_OVR, 1'b0, '0, 3'd0);
    end
  end

  // One-cycle stimulus pulse launched at the current negedge.
  task automatic pulse(input logic bq, input logic [2:0] cnt, input logic pq, input logic [NS-1:0] rel);
    boss_req = bq; boss_count = cnt; player_req = pq; slot_release = rel;
    @(negedge clk_master);
    boss_req = 1'b0; boss_count = 3'd0; player_req = 1'b0; slot_release = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0) && (n < 40)) begin
      @(negedge clk_master);
      n++;
    end
    @(negedge clk_master);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d events outstanding, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk_master);
    rst_n = 1'b0;
    @(negedge clk_master);
    @(negedge clk_master);
    rst_n = 1'b1;
    @(negedge clk_master);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
    chk("rst_slot_busy", {24'd0, slot_busy}, 32'd0);
    chk("rst_boss_busy", {31'd0, boss_busy}, 32'd0);
    chk("rst_pulses", {29'd0, boss_drop, player_drop, boss_overrun}, 32'd0);
    @(negedge clk_master);
    rst_n = 1'b1;
    @(negedge clk_master);

    // Full boss burst: slots 0..4, idx 0..4
    for (int i = 0; i < 5; i++) push_ev(K_GRANT, 1'b0, SW'(i), 3'(i));
    pulse(1'b1, 3'd5, 1'b0, '0);
    chk("t1_boss_busy_rise", {31'd0, boss_busy}, 32'd1);
    drain("t1");
    chk("t1_slot_busy", {24'd0, slot_busy}, 32'h1F);
    chk("t1_boss_busy_fall", {31'd0, boss_busy}, 32'd0);
    chk("t1_slot_owner", {24'd0, slot_owner}, 32'h00);

    // Arbitration interleave
    do_reset();
    push_ev(K_GRANT, 1'b0, 3'd0, 3'd0);
    push_ev(K_GRANT, 1'b1, 3'd1, 3'd0);
    push_ev(K_GRANT, 1'b0, 3'd2, 3'd1);
    push_ev(K_GRANT, 1'b0, 3'd3, 3'd2);
    push_ev(K_GRANT, 1'b0, 3'd4, 3'd3);
    push_ev(K_GRANT, 1'b0, 3'd5, 3'd4);
    pulse(1'b1, 3'd5, 1'b1, '0);
    drain("t2");
    chk("t2_slot_owner", {24'd0, slot_owner}, 32'h02);
    chk("t2_slot_busy", {24'd0, slot_busy}, 32'h3F);

    // Boss drop on full pool (slots 0..5 busy)
    push_ev(K_GRANT, 1'b0, 3'd6, 3'd0);
    push_ev(K_GRANT, 1'b0, 3'd7, 3'd1);
    push_ev(K_BDROP, 1'b0, 3'd0, 3'd0);
    pulse(1'b1, 3'd4, 1'b0, '0);
    drain("t3");
    chk("t3_boss_busy", {31'd0, boss_busy}, 32'd0);
    chk("t3_slot_busy", {24'd0, slot_busy}, 32'hFF);

    // Release timing: release slot 3 with a player request, pool full
    push_ev(K_GRANT, 1'b1, 3'd3, 3'd0);
    pulse(1'b0, 3'd0, 1'b1, 8'h08);
    chk("t4_slot3_freed", {24'd0, slot_busy}, 32'hF7);
    drain("t4");
    chk("t4_slot_busy", {24'd0, slot_busy}, 32'hFF);
    chk("t4_slot_owner", {24'd0, slot_owner}, 32'h0A);
    push_ev(K_PDROP, 1'b0, 3'd0, 3'd0);
    pulse(1'b0, 3'd0, 1'b1, '0);
    drain("t4_pdrop");

    // Overrun during a burst, then clamp of 7 to 5, then count 0
    do_reset();
    push_ev(K_GRANT, 1'b0, 3'd0, 3'd0);
    push_ev(K_GRANT, 1'b0, 3'd1, 3'd1);
    push_ev(K_OVR, 1'b0, 3'd0, 3'd0);
    push_ev(K_GRANT, 1'b0, 3'd2, 3'd2);
    pulse(1'b1, 3'd3, 1'b0, '0);
    @(negedge clk_master);
    pulse(1'b1, 3'd5, 1'b0, '0);
    drain("t5_ovr");
    chk("t5_slot_busy", {24'd0, slot_busy}, 32'h07);
    for (int i = 0; i < 5; i++) push_ev(K_GRANT, 1'b0, SW'(i + 3), 3'(i));
    pulse(1'b1, 3'd7, 1'b0, '0);
    drain("t5_clamp");
    chk("t5_full", {24'd0, slot_busy}, 32'hFF);
    pulse(1'b1, 3'd0, 1'b0, '0);
    chk("t5_zero_busy", {31'd0, boss_busy}, 32'd0);
    repeat (4) @(negedge clk_master);
    chk("t5_zero_nogrant", q.size(), 32'd0);

    // Reset mid-burst
    do_reset();
    push_ev(K_GRANT, 1'b0, 3'd0, 3'd0);
    push_ev(K_GRANT, 1'b0, 3'd1, 3'd1);
    pulse(1'b1, 3'd5, 1'b0, '0);
    @(negedge clk_master);
    @(negedge clk_master);
    @(posedge clk_master);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_grant_valid", {31'd0, grant_valid}, 32'd0);
    chk("t6_slot_busy", {24'd0, slot_busy}, 32'd0);
    chk("t6_boss_busy", {31'd0, boss_busy}, 32'd0);
    chk("t6_grant_fields", {24'd0, grant_owner, grant_slot, grant_idx, boss_drop}, 32'd0);
    chk("t6_q_popped", q.size(), 32'd0);
    @(negedge clk_master);
    rst_n = 1'b1;
    @(negedge clk_master);
    push_ev(K_GRANT, 1'b1, 3'd0, 3'd0);
    pulse(1'b0, 3'd0, 1'b1, '0);
    drain("t6_player");
    chk("t6_slot_busy_after", {24'd0, slot_busy}, 32'h01);

    chk("final_queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
